// File: rtl/frame_serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data,
// optional even parity, stop bit. Every output is driven straight from a flop.
module frame_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_line,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // The +1 keeps both counters at least one bit wide when a parameter is 1.
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    even_parity = ^word;
  endfunction

  logic [2:0]        state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              par;
  logic              bit_end;

  assign shreg_nxt = shreg >> 1;
  assign bit_end   = (cyc_cnt == CYC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_line  <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            par      <= even_parity(in_data);
            state    <= START;
            tx_line  <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= DATA;
            tx_line <= shreg[0];
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            shreg   <= shreg_nxt;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state   <= PARITY;
                tx_line <= par;
              end else begin
                state   <= STOP;
                tx_line <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx_line <= shreg_nxt[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= STOP;
            tx_line <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            // The done cycle is already IDLE with in_ready high, so a new
            // word can be taken without an extra turnaround cycle.
            cyc_cnt  <= '0;
            state    <= IDLE;
            tx_line  <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            done     <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cyc_cnt  <= '0;
          bit_cnt  <= '0;
          tx_line  <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serial_tx.sv
// Directed bench for frame_serial_tx: default instance plus a
// CLKS_PER_BIT=1, no-parity instance. Outputs sampled on the falling edge.
module tb_frame_serial_tx;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, tx_line, busy, done;
  logic [7:0] in_data;
  logic       in_valid2, in_ready2, tx_line2, busy2, done2;
  logic [7:0] in_data2;

  int checks;
  int errors;

  frame_serial_tx dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx_line(tx_line), .busy(busy), .done(done)
  );

  frame_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_fast (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .tx_line(tx_line2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    in_valid2 = 1'b1; in_data2 = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (tx_line !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d tx=%b rdy=%b busy=%b done=%b required 1 1 0 0",
                 k, tx_line, in_ready, busy, done);
      end
      checks++;
      if (tx_line2 !== 1'b1 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_fast cyc=%0d tx=%b busy=%b required 1 0", k, tx_line2, busy2);
      end
    end
    in_valid = 1'b0; in_valid2 = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (tx_line !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d tx=%b busy=%b rdy=%b required 1 0 1",
                 k, tx_line, busy, in_ready);
      end
    end
  endtask

  task automatic test_single_a5();
    logic [10:0] seq;
    int ndone;
    seq = {1'b1, 1'b0, 8'hA5, 1'b0};
    ndone = 0;
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    for (int k = 0; k < 48; k++) begin
      if (k < 44) begin
        checks++;
        if (tx_line !== seq[k/4]) begin
          errors++;
          $display("FAIL a5_bit cyc=%0d tx=%b required %b", k, tx_line, seq[k/4]);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL a5_busy cyc=%0d busy=%b rdy=%b required 1 0", k, busy, in_ready);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (k != 44) begin
          errors++;
          $display("FAIL a5_done_time done at cyc %0d required 44", k);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL a5_done_count got %0d required 1", ndone);
    end
    checks++;
    if (tx_line !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_idle tx=%b busy=%b required 1 0", tx_line, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seq1, seq2;
    int ndone;
    seq1 = {1'b1, 1'b1, 8'h01, 1'b0};
    seq2 = {1'b1, 1'b1, 8'h80, 1'b0};
    ndone = 0;
    in_valid = 1'b1; in_data = 8'h01;
    @(negedge clk);
    for (int k = 0; k < 96; k++) begin
      if (k == 44) begin
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b1 || tx_line !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap done=%b rdy=%b tx=%b required 1 1 1", done, in_ready, tx_line);
        end
        in_data = 8'h80;
      end
      if (k == 45) in_valid = 1'b0;
      if (k < 44) begin
        checks++;
        if (tx_line !== seq1[k/4]) begin
          errors++;
          $display("FAIL b2b_first_bit cyc=%0d tx=%b required %b", k, tx_line, seq1[k/4]);
        end
      end else if (k >= 45 && k < 89) begin
        checks++;
        if (tx_line !== seq2[(k-45)/4]) begin
          errors++;
          $display("FAIL b2b_second_bit cyc=%0d tx=%b required %b", k, tx_line, seq2[(k-45)/4]);
        end
      end
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d required 2", ndone);
    end
    checks++;
    if (busy !== 1'b0 || tx_line !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle busy=%b tx=%b required 0 1", busy, tx_line);
    end
  endtask

  task automatic test_data_change();
    logic [10:0] seq;
    seq = {1'b1, 1'b0, 8'h3C, 1'b0};
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k == 8) begin in_valid = 1'b1; in_data = 8'hFF; end
      if (k == 40) in_valid = 1'b0;
      if (k < 44) begin
        checks++;
        if (tx_line !== seq[k/4]) begin
          errors++;
          $display("FAIL chg_bit cyc=%0d tx=%b required %b", k, tx_line, seq[k/4]);
        end
      end else begin
        checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL chg_no_ff cyc=%0d tx=%b busy=%b required 1 0", k, tx_line, busy);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] seq;
    int ndone;
    seq = {1'b1, 1'b0, 8'h0F, 1'b0};
    ndone = 0;
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 13; k++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre busy=%b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_line !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async tx=%b busy=%b rdy=%b done=%b required 1 0 1 0",
               tx_line, busy, in_ready, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || tx_line !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_no_done done_pulses=%0d tx=%b required 0 1", ndone, tx_line);
    end
    in_valid = 1'b1; in_data = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 46; k++) begin
      if (k < 44) begin
        checks++;
        if (tx_line !== seq[k/4]) begin
          errors++;
          $display("FAIL rstmid_0f_bit cyc=%0d tx=%b required %b", k, tx_line, seq[k/4]);
        end
      end
      if (k == 44) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_0f_done done=%b required 1", done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fast_ff();
    logic [9:0] seq;
    int nbusy;
    seq = {1'b1, 8'hFF, 1'b0};
    nbusy = 0;
    in_valid2 = 1'b1; in_data2 = 8'hFF;
    @(negedge clk);
    in_valid2 = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k < 10) begin
        checks++;
        if (tx_line2 !== seq[k]) begin
          errors++;
          $display("FAIL fast_bit cyc=%0d tx=%b required %b", k, tx_line2, seq[k]);
        end
      end
      checks++;
      if (done2 !== (k == 10)) begin
        errors++;
        $display("FAIL fast_done cyc=%0d done=%b required %b", k, done2, (k == 10));
      end
      if (busy2 === 1'b1) nbusy++;
      @(negedge clk);
    end
    checks++;
    if (nbusy != 10) begin
      errors++;
      $display("FAIL fast_busy_len got %0d required 10", nbusy);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_valid2 = 1'b0; in_data2 = 8'h00;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_data_change();
    test_reset_mid();
    test_fast_ff();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
